// File: rtl/esclavo_prueba_mem.sv
// Avalon-MM test slave: small on-chip word memory with programmable
// waitrequest stalls, fixed-latency pipelined reads, saturating access
// counters and a sticky protocol-error flag.
//
// Handshake: the master raises avs_read or avs_write with address, data and
// byteenable stable and holds them until a cycle in which avs_waitrequest is
// low; that cycle is the accept. Every accept stalls exactly WAIT_CYCLES cycles
// first. Read responses need no ready: avs_readdatavalid pulses once per
// accepted read, READ_LATENCY cycles after the accept cycle.
module esclavo_prueba_mem #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 32,
    parameter int WAIT_CYCLES  = 1,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     avs_address,
    input  logic                  avs_read,
    input  logic                  avs_write,
    input  logic [DATA_W-1:0]     avs_writedata,
    input  logic [DATA_W/8-1:0]   avs_byteenable,
    output logic                  avs_waitrequest,
    output logic [DATA_W-1:0]     avs_readdata,
    output logic                  avs_readdatavalid,
    input  logic                  clr_stats,
    output logic [15:0]           wr_count,
    output logic [15:0]           rd_count,
    output logic                  err_flag
);

    localparam int         BYTES    = DATA_W / 8;
    localparam int         DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0] WAIT_LIM = 4'(WAIT_CYCLES);

    // Request tracking: IDLE (no request), STALL (request held while
    // waitrequest is high), ACCEPT (the cycle after an accept).
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STALL  = 2'd1,
        ST_ACCEPT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  stall_cnt;
    logic [3:0]  stall_view;
    logic        req;
    logic        accept;
    logic        wr_acc;
    logic        rd_acc;
    logic        both_acc;

    logic [DATA_W-1:0]                    mem [DEPTH];
    logic [READ_LATENCY-1:0]              vld_pipe;
    logic [READ_LATENCY-1:0][DATA_W-1:0]  dat_pipe;

    // Stall count only carries meaning while a request is being stalled.
    assign stall_view      = (state == ST_STALL) ? stall_cnt : 4'd0;
    assign req             = avs_read | avs_write;
    assign avs_waitrequest = reset | (req & (stall_view < WAIT_LIM));
    assign accept          = req & ~avs_waitrequest;
    // A combined read+write is a master error: only the write is performed.
    assign wr_acc          = accept & avs_write;
    assign rd_acc          = accept & avs_read & ~avs_write;
    assign both_acc        = accept & avs_read & avs_write;

    assign avs_readdatavalid = vld_pipe[READ_LATENCY-1];
    assign avs_readdata      = dat_pipe[READ_LATENCY-1];

    // State register for the request tracker.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: accept wins, a held request stalls, a dropped one idles.
    always_comb begin
        state_next = ST_IDLE;
        if (accept) begin
            state_next = ST_ACCEPT;
        end else if (req) begin
            state_next = ST_STALL;
        end
    end

    // Stall counter: counts waitrequest-high cycles of the current request.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 4'd0;
        end else if (accept || !req) begin
            stall_cnt <= 4'd0;
        end else begin
            stall_cnt <= stall_view + 4'd1;
        end
    end

    // Byte-enabled memory write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int i = 0; i < BYTES; i++) begin
                if (avs_byteenable[i]) begin
                    mem[avs_address][8*i +: 8] <= avs_writedata[8*i +: 8];
                end
            end
        end
    end

    // Read response pipeline: memory sampled at the accept edge, shifted out.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[0] <= rd_acc;
            dat_pipe[0] <= mem[avs_address];
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    // Saturating access counters and sticky error flag; clear wins.
    always_ff @(posedge clk) begin
        if (reset || clr_stats) begin
            wr_count <= 16'd0;
            rd_count <= 16'd0;
            err_flag <= 1'b0;
        end else begin
            if (wr_acc && (wr_count != 16'hFFFF)) begin
                wr_count <= wr_count + 16'd1;
            end
            if (rd_acc && (rd_count != 16'hFFFF)) begin
                rd_count <= rd_count + 16'd1;
            end
            if (both_acc) begin
                err_flag <= 1'b1;
            end
        end
    end

endmodule
